// File: rtl/sb_cfg_mux_array.sv
// Chain-configured array of NUM_MUX routing multiplexers, MUX_SIZE inputs each.
// Optional readback load of the active configuration: define SB_CFG_READBACK_EN.
module sb_cfg_mux_array #(
  parameter int NUM_MUX  = 8,
  parameter int MUX_SIZE = 10,
  localparam int SEL_W    = $clog2(MUX_SIZE),
  localparam int CFG_BITS = NUM_MUX * SEL_W
) (
  input  logic                        prog_clk,
  input  logic                        pReset,
  input  logic                        ccff_head,
  input  logic                        ccff_en,
  input  logic                        cfg_commit,
  input  logic                        cfg_rdbk,
  input  logic [NUM_MUX*MUX_SIZE-1:0] mux_in,
  output logic [NUM_MUX-1:0]          mux_out,
  output logic                        ccff_tail,
  output logic                        cfg_valid,
  output logic                        cfg_err
);

  localparam int CNT_W = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] sr;
  logic [CFG_BITS-1:0] act;
  logic [CFG_BITS-1:0] sr_shifted;
  logic [CNT_W-1:0]    cnt;
  logic                len_ok;

  // Control pulses are sampled on each rising prog_clk edge; no handshake.
  // Priority per edge: cfg_commit, then cfg_rdbk, then ccff_en.
  assign sr_shifted = (sr << 1) | CFG_BITS'(ccff_head);
  assign len_ok     = (cnt == CNT_FULL);
  assign ccff_tail  = sr[CFG_BITS-1];

`ifndef SB_CFG_READBACK_EN
  logic unused_rdbk;
  assign unused_rdbk = cfg_rdbk;
`endif

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr        <= '0;
      act       <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (cfg_commit) begin
      // A commit only takes effect after exactly CFG_BITS shifts.
      if (len_ok) begin
        act       <= sr;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
      cnt <= '0;
`ifdef SB_CFG_READBACK_EN
    end else if (cfg_rdbk) begin
      sr  <= act;
      cnt <= '0;
`endif
    end else if (ccff_en) begin
      sr <= sr_shifted;
      if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic [SEL_W-1:0]    sel;
  logic [MUX_SIZE-1:0] grp;

  // Unused select codes (>= MUX_SIZE) and an unconfigured array both drive 0.
  always_comb begin
    mux_out = '0;
    sel     = '0;
    grp     = '0;
    for (int k = 0; k < NUM_MUX; k++) begin
      sel = act[k*SEL_W +: SEL_W];
      grp = mux_in[k*MUX_SIZE +: MUX_SIZE];
      if (cfg_valid && (int'(sel) < MUX_SIZE)) begin
        mux_out[k] = grp[sel];
      end
    end
  end

endmodule
